// File: rtl/mem_port_arbiter.sv
// Shares one req/addr_ok/data_ok memory port between instruction fetch (I) and load/store (D).
// Optional macro ARB_RR_EN selects round-robin arbitration; when undefined, D has fixed priority over I.
module mem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int OUTS_MAX = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_addr_ok,
    output logic            i_data_ok,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_wr,
    input  logic [XLEN-1:0] d_addr,
    input  logic [3:0]      d_wstrb,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_addr_ok,
    output logic            d_data_ok,
    output logic [XLEN-1:0] d_rdata,
    output logic            ram_req,
    output logic            ram_wr,
    output logic [XLEN-1:0] ram_addr,
    output logic [3:0]      ram_wstrb,
    output logic [XLEN-1:0] ram_wdata,
    input  logic            ram_addr_ok,
    input  logic            ram_data_ok,
    input  logic [XLEN-1:0] ram_rdata
);

    localparam int   PTR_W = (OUTS_MAX > 1) ? $clog2(OUTS_MAX) : 1;
    localparam int   CNT_W = $clog2(OUTS_MAX + 1);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [OUTS_MAX-1:0] own_q, own_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                lock_q, lock_d;
    logic                lock_own_q, lock_own_d;

    logic full, empty, both_req, pref_own, sel_own, win_req;
    logic grant, accept, pop, head_own;

`ifdef ARB_RR_EN
    logic rr_q, rr_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTS_MAX - 1))
            return '0;
        return p + 1'b1;
    endfunction

    assign full     = (cnt_q == CNT_W'(OUTS_MAX));
    assign empty    = (cnt_q == '0);
    assign both_req = i_req && d_req;

    always_comb begin
`ifdef ARB_RR_EN
        pref_own = rr_q;
`else
        pref_own = OWN_D;
`endif
        if (lock_q)
            sel_own = lock_own_q;
        else if (both_req)
            sel_own = pref_own;
        else
            sel_own = d_req ? OWN_D : OWN_I;
    end

    // Gating with rst_b keeps every output at 0 while reset is asserted, even with requests pending.
    assign win_req = (sel_own == OWN_D) ? d_req : i_req;
    assign grant   = rst_b && !full && win_req;
    assign accept  = grant && ram_addr_ok;

    assign ram_req   = grant;
    assign ram_wr    = grant && (sel_own == OWN_D) && d_wr;
    assign ram_addr  = !grant ? '0 : ((sel_own == OWN_D) ? d_addr : i_addr);
    assign ram_wstrb = ram_wr ? d_wstrb : 4'b0000;
    assign ram_wdata = ram_wr ? d_wdata : '0;

    assign i_addr_ok = accept && (sel_own == OWN_I);
    assign d_addr_ok = accept && (sel_own == OWN_D);

    // A response with no outstanding owner is dropped silently.
    assign pop      = ram_data_ok && !empty;
    assign head_own = own_q[rd_ptr_q];

    assign i_data_ok = pop && (head_own == OWN_I);
    assign d_data_ok = pop && (head_own == OWN_D);
    assign i_rdata   = i_data_ok ? ram_rdata : '0;
    assign d_rdata   = d_data_ok ? ram_rdata : '0;

    always_comb begin
        own_d      = own_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        if (accept) begin
            own_d[wr_ptr_q] = sel_own;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            lock_d          = 1'b0;
        end else if (grant) begin
            lock_d     = 1'b1;
            lock_own_d = sel_own;
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(pop);
    end

`ifdef ARB_RR_EN
    always_comb begin
        rr_d = rr_q;
        if (accept && both_req)
            rr_d = ~sel_own;
    end
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            own_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            lock_own_q <= OWN_I;
        end else begin
            own_q      <= own_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            rr_q <= OWN_D;
        else
            rr_q <= rr_d;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_mem_port_arbiter;

    localparam int XLEN     = 32;
    localparam int OUTS_MAX = 2;

    logic            clk;
    logic            rst_b;
    logic            i_req, d_req, d_wr;
    logic [XLEN-1:0] i_addr, d_addr, d_wdata;
    logic [3:0]      d_wstrb;
    logic            i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [XLEN-1:0] i_rdata, d_rdata;
    logic            ram_req, ram_wr, ram_addr_ok, ram_data_ok;
    logic [XLEN-1:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]      ram_wstrb;

    // staged inputs, applied just after the next rising edge
    logic            s_i_req, s_d_req, s_d_wr, s_ram_addr_ok, s_ram_data_ok;
    logic [XLEN-1:0] s_i_addr, s_d_addr, s_d_wdata, s_ram_rdata;
    logic [3:0]      s_d_wstrb;

    // model: owner of each outstanding request (1 = D), lock, RR preference (1 = D)
    bit exp_q[$];
    bit lk_v, lk_d, rr_d;
    bit acc_i, acc_d;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.XLEN(XLEN), .OUTS_MAX(OUTS_MAX)) dut (
        .clk(clk), .rst_b(rst_b),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wstrb(d_wstrb),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata),
        .ram_req(ram_req), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata),
        .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        lk_v = 1'b0;
        lk_d = 1'b0;
        rr_d = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, ram_req, ram_wr, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_wstrb"}, {28'd0, ram_wstrb}, 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_rdata"}, i_rdata | d_rdata, 32'd0);
    endtask

    task automatic stage_idle();
        s_i_req = 0; s_i_addr = 0;
        s_d_req = 0; s_d_wr = 0; s_d_addr = 0; s_d_wstrb = 0; s_d_wdata = 0;
        s_ram_addr_ok = 0; s_ram_data_ok = 0; s_ram_rdata = 0;
    endtask

    // One clock cycle: apply staged inputs, compare at the falling edge, advance the model.
    task automatic step();
        bit full, win_d, wreq, e_req, e_acc, e_pop, head, e_wr;
        logic [31:0] e_addr;
        @(posedge clk);
        #1;
        i_req = s_i_req; i_addr = s_i_addr;
        d_req = s_d_req; d_wr = s_d_wr; d_addr = s_d_addr;
        d_wstrb = s_d_wstrb; d_wdata = s_d_wdata;
        ram_addr_ok = s_ram_addr_ok; ram_data_ok = s_ram_data_ok; ram_rdata = s_ram_rdata;
        @(negedge clk);
        acc_i = 0;
        acc_d = 0;
        if (!rst_b) begin
            chk_all_zero("in_reset");
            model_reset();
            return;
        end
        full = (exp_q.size() == OUTS_MAX);
        if (lk_v)              win_d = lk_d;
        else if (i_req && d_req) win_d = rr_d;
        else                   win_d = d_req;
        wreq  = win_d ? d_req : i_req;
        e_req = !full && wreq;
        e_acc = e_req && ram_addr_ok;
        e_pop = ram_data_ok && (exp_q.size() != 0);
        head  = e_pop ? exp_q[0] : 1'b0;
        e_wr  = e_req && win_d && d_wr;
        e_addr = win_d ? d_addr : i_addr;

        chk("ram_req", {31'd0, ram_req}, {31'd0, e_req});
        chk("i_addr_ok", {31'd0, i_addr_ok}, {31'd0, e_acc && !win_d});
        chk("d_addr_ok", {31'd0, d_addr_ok}, {31'd0, e_acc && win_d});
        chk("i_data_ok", {31'd0, i_data_ok}, {31'd0, e_pop && !head});
        chk("d_data_ok", {31'd0, d_data_ok}, {31'd0, e_pop && head});
        if (e_req) begin
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wr", {31'd0, ram_wr}, {31'd0, e_wr});
            chk("ram_wstrb", {28'd0, ram_wstrb}, e_wr ? {28'd0, d_wstrb} : 32'd0);
            if (e_wr) chk("ram_wdata", ram_wdata, d_wdata);
        end
        if (e_pop && !head) chk("i_rdata", i_rdata, ram_rdata);
        if (e_pop && head)  chk("d_rdata", d_rdata, ram_rdata);

        if (e_acc) begin
            exp_q.push_back(win_d);
            lk_v = 1'b0;
`ifdef ARB_RR_EN
            if (i_req && d_req) rr_d = !win_d;
`endif
        end else if (e_req) begin
            lk_v = 1'b1;
            lk_d = win_d;
        end
        if (e_pop) void'(exp_q.pop_front());
        acc_i = e_acc && !win_d;
        acc_d = e_acc && win_d;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            stage_idle();
            s_ram_data_ok = 1;
            s_ram_rdata = $urandom;
            step();
        end
        stage_idle();
    endtask

    bit i_busy, d_busy;

    initial begin
        rst_b = 1'b0;
        model_reset();
        stage_idle();
        i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wstrb = 0; d_wdata = 0;
        ram_addr_ok = 0; ram_data_ok = 0; ram_rdata = 0;
        step();
        step();
        rst_b = 1'b1;

        // D priority, then I once D drops
        s_i_req = 1; s_i_addr = 32'h200; s_d_req = 1; s_d_addr = 32'h100; s_ram_addr_ok = 1;
        step();
        chk("dprio_d_ok", {31'd0, d_addr_ok}, 32'd1);
        chk("dprio_i_ok", {31'd0, i_addr_ok}, 32'd0);
        chk("dprio_addr", ram_addr, 32'h100);
        s_d_req = 0;
        step();
        chk("dprio_i_next", {31'd0, i_addr_ok}, 32'd1);
        stage_idle();
        s_ram_data_ok = 1; s_ram_rdata = 32'hAAAA0001;
        step();
        chk("dprio_resp_d", {31'd0, d_data_ok}, 32'd1);
        chk("dprio_resp_d_data", d_rdata, 32'hAAAA0001);
        s_ram_rdata = 32'hBBBB0002;
        step();
        chk("dprio_resp_i", {31'd0, i_data_ok}, 32'd1);
        chk("dprio_resp_i_data", i_rdata, 32'hBBBB0002);

        // lock holds I against a later D request
        stage_idle();
        s_i_req = 1; s_i_addr = 32'h300;
        for (int k = 0; k < 3; k++) step();
        s_d_req = 1; s_d_addr = 32'h400;
        step();
        chk("lock_addr", ram_addr, 32'h300);
        chk("lock_d_ok", {31'd0, d_addr_ok}, 32'd0);
        s_ram_addr_ok = 1;
        step();
        chk("lock_i_acc", {31'd0, i_addr_ok}, 32'd1);
        chk("lock_d_wait", {31'd0, d_addr_ok}, 32'd0);
        s_i_req = 0;
        step();
        chk("lock_d_after", {31'd0, d_addr_ok}, 32'd1);
        drain(2);

        // FIFO full blocks the port; a same-cycle pop frees the slot only next cycle
        s_i_req = 1; s_i_addr = 32'h0; s_ram_addr_ok = 1;
        step();
        s_i_req = 0; s_d_req = 1; s_d_addr = 32'h4;
        step();
        s_d_req = 0; s_i_req = 1; s_i_addr = 32'h8;
        step();
        chk("full_req", {31'd0, ram_req}, 32'd0);
        chk("full_i_ok", {31'd0, i_addr_ok}, 32'd0);
        s_ram_data_ok = 1; s_ram_rdata = 32'hDEADBEEF;
        step();
        chk("full_pop_ok", {31'd0, i_data_ok}, 32'd1);
        chk("full_pop_data", i_rdata, 32'hDEADBEEF);
        chk("full_pop_req", {31'd0, ram_req}, 32'd0);
        s_ram_data_ok = 0;
        step();
        chk("full_resume_req", {31'd0, ram_req}, 32'd1);
        chk("full_resume_ok", {31'd0, i_addr_ok}, 32'd1);
        drain(2);

        // store ack
        s_d_req = 1; s_d_wr = 1; s_d_addr = 32'h10; s_d_wstrb = 4'b0011; s_d_wdata = 32'h1234;
        s_ram_addr_ok = 1;
        step();
        chk("st_wstrb", {28'd0, ram_wstrb}, 32'h3);
        chk("st_wr", {31'd0, ram_wr}, 32'd1);
        chk("st_wdata", ram_wdata, 32'h1234);
        stage_idle();
        s_ram_data_ok = 1;
        step();
        chk("st_ack", {31'd0, d_data_ok}, 32'd1);

        // async reset with two outstanding
        stage_idle();
        s_i_req = 1; s_i_addr = 32'h20; s_ram_addr_ok = 1;
        step();
        s_i_req = 0; s_d_req = 1; s_d_addr = 32'h24;
        step();
        s_i_req = 1; s_ram_addr_ok = 1;
        step();
        #2;
        rst_b = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        stage_idle();
        step();
        step();
        rst_b = 1'b1;
        s_ram_data_ok = 1; s_ram_rdata = 32'h5555AAAA;
        step();
        chk("rst_spur_i", {31'd0, i_data_ok}, 32'd0);
        chk("rst_spur_d", {31'd0, d_data_ok}, 32'd0);
        stage_idle();

        // randomized traffic
        i_busy = 0;
        d_busy = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!i_busy && $urandom_range(0, 2) == 0) begin
                i_busy = 1;
                s_i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_busy && $urandom_range(0, 2) == 0) begin
                d_busy = 1;
                s_d_wr = 1'($urandom_range(0, 1));
                s_d_addr = $urandom & 32'hFFFF_FFFC;
                s_d_wstrb = 4'($urandom_range(1, 15));
                s_d_wdata = $urandom;
            end
            s_i_req = i_busy;
            s_d_req = d_busy;
            s_ram_addr_ok = ($urandom_range(0, 3) != 0);
            if (exp_q.size() != 0) s_ram_data_ok = ($urandom_range(0, 2) == 0);
            else                   s_ram_data_ok = ($urandom_range(0, 7) == 0);
            s_ram_rdata = $urandom;
            step();
            if (acc_i) i_busy = 0;
            if (acc_d) d_busy = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
